// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the binary conv sequencer.
package bnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    EMIT,
    DONE
  } seq_state_e;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pool_size(input int img, input int ks);
    return (img - ks + 1) / 2;
  endfunction

endpackage

// File: rtl/bnn_loop_counter.sv
// Nested index counter, innermost first: kx, ky, ic, dx, dy, px, py, oc.
module bnn_loop_counter
  import bnn_pkg::*;
#(
  parameter int KS  = 3,
  parameter int IN  = 1,
  parameter int P   = 14,
  parameter int OUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  output logic [width_of(KS)-1:0]  kx,
  output logic [width_of(KS)-1:0]  ky,
  output logic [width_of(IN)-1:0]  ic,
  output logic                     dx,
  output logic                     dy,
  output logic [width_of(P)-1:0]   px,
  output logic [width_of(P)-1:0]   py,
  output logic [width_of(OUT)-1:0] oc,
  output logic [7:0]               wrap
);

  localparam int KW = width_of(KS);
  localparam int IW = width_of(IN);
  localparam int PW = width_of(P);
  localparam int OW = width_of(OUT);

  logic [7:0] step;

  // wrap[i]: level i sits at its last value and rolls over on the next step
  assign wrap[0] = (kx == KW'(KS - 1));
  assign wrap[1] = (ky == KW'(KS - 1));
  assign wrap[2] = (ic == IW'(IN - 1));
  assign wrap[3] = dx;
  assign wrap[4] = dy;
  assign wrap[5] = (px == PW'(P - 1));
  assign wrap[6] = (py == PW'(P - 1));
  assign wrap[7] = (oc == OW'(OUT - 1));

  always_comb begin
    step[0] = advance;
    for (int i = 1; i < 8; i++) step[i] = step[i-1] & wrap[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kx <= '0; ky <= '0; ic <= '0; dx <= 1'b0;
      dy <= 1'b0; px <= '0; py <= '0; oc <= '0;
    end else begin
      if (step[0]) kx <= wrap[0] ? '0 : kx + 1'b1;
      if (step[1]) ky <= wrap[1] ? '0 : ky + 1'b1;
      if (step[2]) ic <= wrap[2] ? '0 : ic + 1'b1;
      if (step[3]) dx <= ~dx;
      if (step[4]) dy <= ~dy;
      if (step[5]) px <= wrap[5] ? '0 : px + 1'b1;
      if (step[6]) py <= wrap[6] ? '0 : py + 1'b1;
      if (step[7]) oc <= wrap[7] ? '0 : oc + 1'b1;
    end
  end

endmodule

// File: rtl/bnn_conv_sequencer.sv
// Serial binary conv + 2x2 max-pool controller around one XNOR/popcount tap.
// Define BNN_SEQ_PERF_EN to build the busy-cycle counter on perf_cycles.
module bnn_conv_sequencer
  import bnn_pkg::*;
#(
  parameter int IMG_IN_SIZE     = 30,
  parameter int KERNEL_SIZE     = 3,
  parameter int BNN_IN_CHANL    = 1,
  parameter int BNN_OUT_CHANL   = 8,
  parameter int THRESHOLD_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [width_of(BNN_IN_CHANL*IMG_IN_SIZE*IMG_IN_SIZE)-1:0] pix_addr,
  input  logic pix_data,
  output logic [width_of(BNN_OUT_CHANL*BNN_IN_CHANL*KERNEL_SIZE*KERNEL_SIZE)-1:0] wgt_addr,
  input  logic wgt_data,
  input  logic [BNN_OUT_CHANL*THRESHOLD_WIDTH-1:0] thresholds,
  output logic out_valid,
  input  logic out_ready,
  output logic [width_of(BNN_OUT_CHANL*pool_size(IMG_IN_SIZE, KERNEL_SIZE)*pool_size(IMG_IN_SIZE, KERNEL_SIZE))-1:0] out_addr,
  output logic out_bit,
  output logic [31:0] perf_cycles
);

  localparam int IMG   = IMG_IN_SIZE;
  localparam int KS    = KERNEL_SIZE;
  localparam int P     = pool_size(IMG_IN_SIZE, KERNEL_SIZE);
  localparam int PIX_W = width_of(BNN_IN_CHANL*IMG*IMG);
  localparam int WGT_W = width_of(BNN_OUT_CHANL*BNN_IN_CHANL*KS*KS);
  localparam int OUT_W = width_of(BNN_OUT_CHANL*P*P);
  localparam int ACC_W = width_of(BNN_IN_CHANL*KS*KS + 1);
  localparam int CMP_W = (ACC_W > THRESHOLD_WIDTH) ? ACC_W : THRESHOLD_WIDTH;

  seq_state_e state;

  logic [width_of(KS)-1:0]            kx, ky;
  logic [width_of(BNN_IN_CHANL)-1:0]  ic;
  logic                               dx, dy;
  logic [width_of(P)-1:0]             px, py, cur_px, cur_py;
  logic [width_of(BNN_OUT_CHANL)-1:0] oc, cur_oc;
  logic [7:0]                         wrap;

  logic             load, data_valid, data_last, match, win_bit, pool;
  logic             addr_tap_last, addr_pix_last, addr_final;
  logic [ACC_W-1:0] acc;
  logic [PIX_W-1:0] pix_next;
  logic [WGT_W-1:0] wgt_next;
  logic [OUT_W-1:0] out_next;
  logic [THRESHOLD_WIDTH-1:0] thr;

  // load latches the counter's current tap into the address registers
  assign load = (state == IDLE && start) ||
                (state == RUN && !addr_pix_last) ||
                (state == EMIT && out_ready && !addr_final);

  bnn_loop_counter #(
    .KS (KS),
    .IN (BNN_IN_CHANL),
    .P  (P),
    .OUT(BNN_OUT_CHANL)
  ) u_loop (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(load),
    .kx     (kx),
    .ky     (ky),
    .ic     (ic),
    .dx     (dx),
    .dy     (dy),
    .px     (px),
    .py     (py),
    .oc     (oc),
    .wrap   (wrap)
  );

  assign pix_next = PIX_W'(32'(ic) * 32'(IMG*IMG)
                  + (32'(py) * 32'd2 + 32'(dy) + 32'(ky)) * 32'(IMG)
                  + 32'(px) * 32'd2 + 32'(dx) + 32'(kx));
  assign wgt_next = WGT_W'(((32'(oc) * 32'(BNN_IN_CHANL) + 32'(ic)) * 32'(KS)
                  + 32'(ky)) * 32'(KS) + 32'(kx));
  assign out_next = OUT_W'(32'(cur_oc) * 32'(P*P) + 32'(cur_py) * 32'(P) + 32'(cur_px));

  assign thr     = thresholds[cur_oc*THRESHOLD_WIDTH +: THRESHOLD_WIDTH];
  assign match   = ~(pix_data ^ wgt_data);
  assign win_bit = (CMP_W'(acc) + CMP_W'(match)) >= CMP_W'(thr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pix_addr      <= '0;
      wgt_addr      <= '0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_bit       <= 1'b0;
      data_valid    <= 1'b0;
      data_last     <= 1'b0;
      addr_tap_last <= 1'b0;
      addr_pix_last <= 1'b0;
      addr_final    <= 1'b0;
      cur_oc        <= '0;
      cur_py        <= '0;
      cur_px        <= '0;
      acc           <= '0;
      pool          <= 1'b0;
    end else begin
      data_valid <= (state == RUN);
      data_last  <= (state == RUN) && addr_tap_last;
      done       <= 1'b0;
      if (load) begin
        pix_addr      <= pix_next;
        wgt_addr      <= wgt_next;
        addr_tap_last <= &wrap[2:0];
        addr_pix_last <= &wrap[4:0];
        addr_final    <= &wrap;
        cur_oc        <= oc;
        cur_py        <= py;
        cur_px        <= px;
      end
      if (data_valid) begin
        if (data_last) begin
          acc  <= '0;
          pool <= pool | win_bit;
        end else begin
          acc <= acc + ACC_W'(match);
        end
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (addr_pix_last) state <= DRAIN;
        DRAIN: begin
          state     <= EMIT;
          out_valid <= 1'b1;
          out_bit   <= pool | win_bit;
          out_addr  <= out_next;
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          pool      <= 1'b0;
          if (addr_final) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BNN_SEQ_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk) begin
    if (!rst_n) perf <= '0;
    else if (state == IDLE && start) perf <= '0;
    else if (busy && perf != '1) perf <= perf + 32'd1;
  end

  assign perf_cycles = perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_bnn_conv_sequencer.sv
// Scoreboard bench for bnn_conv_sequencer on a 6x6 image, 2 output channels.
module tb_bnn_conv_sequencer;

  localparam int IMG = 6, KS = 3, IN = 1, OUT = 2, TW = 8, P = 2;
  localparam int PIX_W = 6, WGT_W = 5, OUT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done;
  logic [PIX_W-1:0] pix_addr;
  logic             pix_data = 1'b0;
  logic [WGT_W-1:0] wgt_addr;
  logic             wgt_data = 1'b0;
  logic [OUT*TW-1:0] thresholds = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_addr;
  logic             out_bit;
  logic [31:0]      perf_cycles;

  typedef struct {
    int addr;
    bit val;
  } exp_t;

  exp_t sb[$];
  bit   img[IMG*IMG];
  bit   wgt[OUT*IN*KS*KS];
  int   thr[OUT];
  int   exp_pix[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  int   n_checks = 0;
  int   n_fail = 0;

  bnn_conv_sequencer #(
    .IMG_IN_SIZE    (IMG),
    .KERNEL_SIZE    (KS),
    .BNN_IN_CHANL   (IN),
    .BNN_OUT_CHANL  (OUT),
    .THRESHOLD_WIDTH(TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .wgt_addr   (wgt_addr),
    .wgt_data   (wgt_data),
    .thresholds (thresholds),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_bit    (out_bit),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pix_data <= (int'(pix_addr) < IMG*IMG) ? img[pix_addr] : 1'b0;
    wgt_data <= (int'(wgt_addr) < OUT*IN*KS*KS) ? wgt[wgt_addr] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_bit"}, 32'(out_bit), 0);
    check({tag, "_out_addr"}, 32'(out_addr), 0);
    check({tag, "_pix_addr"}, 32'(pix_addr), 0);
    check({tag, "_wgt_addr"}, 32'(wgt_addr), 0);
    check({tag, "_perf"}, perf_cycles, 0);
  endtask

  // reference conv + threshold + pool straight from the layer definition
  task automatic push_expected();
    for (int oc = 0; oc < OUT; oc++)
      for (int py = 0; py < P; py++)
        for (int px = 0; px < P; px++) begin
          exp_t e;
          bit b = 1'b0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              int cnt = 0;
              for (int ic = 0; ic < IN; ic++)
                for (int ky = 0; ky < KS; ky++)
                  for (int kx = 0; kx < KS; kx++) begin
                    bit p = img[ic*IMG*IMG + (2*py+dy+ky)*IMG + 2*px+dx+kx];
                    bit w = wgt[((oc*IN+ic)*KS+ky)*KS+kx];
                    if (p == w) cnt++;
                  end
              if (cnt >= thr[oc]) b = 1'b1;
            end
          e.addr = oc*P*P + py*P + px;
          e.val  = b;
          sb.push_back(e);
        end
  endtask

  task automatic setup(input bit img_ones, input bit wgt_ones, input int t);
    for (int i = 0; i < IMG*IMG; i++) img[i] = img_ones;
    for (int i = 0; i < OUT*IN*KS*KS; i++) wgt[i] = wgt_ones;
    for (int c = 0; c < OUT; c++) begin
      thr[c] = t;
      thresholds[c*TW +: TW] = TW'(t);
    end
  endtask

  task automatic run_pass(input string tag, input int stall_n, input bit restart_mid,
                          input int reset_at, input int exp_busy, input bit chk_addr);
    int busy_cnt = 0;
    int stall_left = stall_n;
    int guard = 0;
    bit finished = 1'b0;
    bit stall_ok = 1'b1;
    exp_t e;
    logic [OUT_W-1:0] ref_oaddr = '0;
    logic             ref_obit = 1'b0;
    logic [PIX_W-1:0] ref_pix = '0;
    logic [WGT_W-1:0] ref_wgt = '0;
    logic [PIX_W-1:0] pix_seen[9];
    logic [WGT_W-1:0] wgt_seen[9];

    sb.delete();
    push_expected();
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && guard < 2000) begin
      guard++;
      if (busy) busy_cnt++;
      start = restart_mid && busy && (busy_cnt == 20);
      if (reset_at > 0 && busy_cnt == reset_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle({tag, "_midreset"});
        sb.delete();
        return;
      end
      if (chk_addr && busy && busy_cnt <= 9) begin
        pix_seen[busy_cnt-1] = pix_addr;
        wgt_seen[busy_cnt-1] = wgt_addr;
      end
      if (done) finished = 1'b1;
      out_ready = 1'b1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == stall_n) begin
          ref_oaddr = out_addr; ref_obit = out_bit;
          ref_pix = pix_addr;   ref_wgt = wgt_addr;
        end else if (out_addr !== ref_oaddr || out_bit !== ref_obit ||
                     pix_addr !== ref_pix || wgt_addr !== ref_wgt) begin
          stall_ok = 1'b0;
        end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check({tag, "_extra_output"}, 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check({tag, "_out_addr"}, 32'(out_addr), 32'(e.addr));
          check({tag, "_out_bit"}, 32'(out_bit), 32'(e.val));
        end
      end
      @(posedge clk); #1;
    end
    check({tag, "_finished"}, 32'(finished), 1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_done_one_cycle"}, 32'(done), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_missing_outputs"}, sb.size(), 0);
    if (stall_n > 0) check({tag, "_stall_hold"}, 32'(stall_ok), 1);
    if (chk_addr)
      for (int i = 0; i < 9; i++) begin
        check($sformatf("%s_pix_addr%0d", tag, i), 32'(pix_seen[i]), exp_pix[i]);
        check($sformatf("%s_wgt_addr%0d", tag, i), 32'(wgt_seen[i]), i);
      end
`ifdef BNN_SEQ_PERF_EN
    check({tag, "_perf"}, perf_cycles, exp_busy);
`else
    check({tag, "_perf"}, perf_cycles, 0);
`endif
  endtask

  initial begin
    setup(1'b1, 1'b1, 9);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass("ones_t9", 0, 1'b0, 0, 304, 1'b1);
    setup(1'b1, 1'b1, 10);
    run_pass("ones_t10", 0, 1'b0, 0, 304, 1'b0);
    setup(1'b1, 1'b0, 0);
    run_pass("zero_wgt_t0", 0, 1'b0, 0, 304, 1'b0);
    setup(1'b0, 1'b1, 1);
    img[0] = 1'b1;
    run_pass("pool_or", 0, 1'b0, 0, 304, 1'b0);
    setup(1'b1, 1'b1, 9);
    run_pass("stall", 5, 1'b0, 0, 309, 1'b0);
    setup(1'b0, 1'b1, 1);
    img[0] = 1'b1;
    run_pass("restart_ignored", 0, 1'b1, 0, 304, 1'b0);
    setup(1'b1, 1'b1, 9);
    run_pass("abort", 0, 1'b0, 50, 304, 1'b0);
    @(posedge clk); #1;
    run_pass("after_reset", 0, 1'b0, 0, 304, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
